// File: rtl/dram_pkg.sv
// Shared types, pin encodings and default timing for the DRAM pin-interface controller.
package dram_pkg;

    localparam int DRAM_A_W       = 11;
    localparam int DEF_ROW_W      = 11;
    localparam int DEF_COL_W      = 10;
    localparam int DEF_T_RP       = 5;
    localparam int DEF_T_RCD      = 5;
    localparam int DEF_T_WR       = 5;
    localparam int DEF_T_RD_MAX   = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_PRE_W,
        S_ACT,
        S_ACT_W,
        S_CMD,
        S_WR_W,
        S_RD_W,
        S_RESP
    } dram_state_e;

    typedef struct packed {
        logic       csn;
        logic       rasn;
        logic       casn;
        logic [3:0] wen;
    } dram_pins_t;

    localparam dram_pins_t PINS_NOP = '{csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
    localparam dram_pins_t PINS_PRE = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'h0};
    localparam dram_pins_t PINS_ACT = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'hF};
    localparam dram_pins_t PINS_RD  = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'hF};
    // WEn of a write is replaced by the inverted byte strobes.
    localparam dram_pins_t PINS_WR  = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'hF};

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dram_timer.sv
// Loadable down-counter; done is high on the last cycle of a loaded wait.
module dram_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt <= CNT_W'(1));

endmodule

// File: rtl/dram_ctrl.sv
// Single-word DRAM initiator: open-page policy with one tracked row, registered command pins.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int ROW_W    = DEF_ROW_W,
    parameter int COL_W    = DEF_COL_W,
    parameter int T_RP     = DEF_T_RP,
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_WR     = DEF_T_WR,
    parameter int T_RD_MAX = DEF_T_RD_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ROW_W+COL_W-1:0] req_addr,
    input  logic [31:0]            req_wdata,
    input  logic [3:0]             req_wstrb,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   DRAM_CSn,
    output logic                   DRAM_RASn,
    output logic                   DRAM_CASn,
    output logic [3:0]             DRAM_WEn,
    output logic [10:0]            DRAM_A,
    output logic [31:0]            DRAM_D,
    input  logic [31:0]            DRAM_Q,
    input  logic                   DRAM_valid
);

    localparam int T_MAX = max_of4(T_RP, T_RCD, T_WR, T_RD_MAX);
    localparam int CNT_W = $clog2(T_MAX) + 1;

    dram_state_e state, state_nxt;

    logic [ROW_W+COL_W-1:0] addr_q;
    logic                   write_q;
    logic [31:0]            wdata_q;
    logic [3:0]             wstrb_q;
    logic                   open_vld;
    logic [ROW_W-1:0]       open_row;

    logic                   accept;
    logic [ROW_W+COL_W-1:0] cur_addr;
    logic                   cur_write;
    logic [31:0]            cur_wdata;
    logic [3:0]             cur_wstrb;
    logic [ROW_W-1:0]       cur_row;
    logic [COL_W-1:0]       cur_col;

    logic                   tmr_load;
    logic [CNT_W-1:0]       tmr_val;
    logic                   tmr_done;
    logic                   rsp_cap;
    logic                   rsp_to;

    dram_pins_t             pins_q, pins_nxt;
    logic [10:0]            a_q, a_nxt;
    logic [31:0]            d_q, d_nxt;

    assign accept    = req_valid && (state == S_IDLE);
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    // In IDLE the request is not latched yet, so decisions and the first command use the live inputs.
    assign cur_addr  = (state == S_IDLE) ? req_addr  : addr_q;
    assign cur_write = (state == S_IDLE) ? req_write : write_q;
    assign cur_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
    assign cur_wstrb = (state == S_IDLE) ? req_wstrb : wstrb_q;
    assign cur_row   = cur_addr[COL_W+ROW_W-1:COL_W];
    assign cur_col   = cur_addr[COL_W-1:0];

    dram_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        rsp_cap   = 1'b0;
        rsp_to    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_write && (req_wstrb == 4'h0)) begin
                        state_nxt = S_RESP;
                    end else if (open_vld && (cur_row == open_row)) begin
                        state_nxt = S_CMD;
                    end else if (open_vld) begin
                        state_nxt = S_PRE;
                    end else begin
                        state_nxt = S_ACT;
                    end
                end
            end
            S_PRE: begin
                tmr_load  = 1'b1;
                tmr_val   = CNT_W'(T_RP);
                state_nxt = (T_RP == 0) ? S_ACT : S_PRE_W;
            end
            S_PRE_W: if (tmr_done) state_nxt = S_ACT;
            S_ACT: begin
                tmr_load  = 1'b1;
                tmr_val   = CNT_W'(T_RCD);
                state_nxt = (T_RCD == 0) ? S_CMD : S_ACT_W;
            end
            S_ACT_W: if (tmr_done) state_nxt = S_CMD;
            S_CMD: begin
                tmr_load = 1'b1;
                if (write_q) begin
                    tmr_val   = CNT_W'(T_WR);
                    state_nxt = (T_WR == 0) ? S_RESP : S_WR_W;
                end else begin
                    tmr_val   = CNT_W'(T_RD_MAX);
                    rsp_to    = (T_RD_MAX == 0);
                    state_nxt = (T_RD_MAX == 0) ? S_RESP : S_RD_W;
                end
            end
            S_WR_W: if (tmr_done) state_nxt = S_RESP;
            S_RD_W: begin
                if (DRAM_valid) begin
                    rsp_cap   = 1'b1;
                    state_nxt = S_RESP;
                end else if (tmr_done) begin
                    rsp_to    = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command states last exactly one cycle, so keying pins off the next state yields single-cycle commands.
    always_comb begin
        pins_nxt = PINS_NOP;
        a_nxt    = '0;
        d_nxt    = '0;
        case (state_nxt)
            S_PRE: begin
                pins_nxt = PINS_PRE;
                a_nxt    = DRAM_A_W'(open_row);
            end
            S_ACT: begin
                pins_nxt = PINS_ACT;
                a_nxt    = DRAM_A_W'(cur_row);
            end
            S_CMD: begin
                a_nxt = DRAM_A_W'(cur_col);
                if (cur_write) begin
                    pins_nxt     = PINS_WR;
                    pins_nxt.wen = ~cur_wstrb;
                    d_nxt        = cur_wdata;
                end else begin
                    pins_nxt = PINS_RD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            open_vld  <= 1'b0;
            pins_q    <= PINS_NOP;
            a_q       <= '0;
            d_q       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state  <= state_nxt;
            pins_q <= pins_nxt;
            a_q    <= a_nxt;
            d_q    <= d_nxt;
            if (state == S_PRE) open_vld <= 1'b0;
            if (state == S_ACT) open_vld <= 1'b1;
            if (accept) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
            if (rsp_cap) rsp_rdata <= DRAM_Q;
            if (rsp_to)  rsp_err   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
        if (state == S_ACT) open_row <= addr_q[COL_W+ROW_W-1:COL_W];
    end

    assign DRAM_CSn  = pins_q.csn;
    assign DRAM_RASn = pins_q.rasn;
    assign DRAM_CASn = pins_q.casn;
    assign DRAM_WEn  = pins_q.wen;
    assign DRAM_A    = a_q;
    assign DRAM_D    = d_q;

endmodule
